muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; port names and order are as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 alu_op  input  6  operation code from the control unit: MULT 6'b011000, MULTU 6'b011001, DIV 6'b011010, DIVU 6'b011011.
REQ-006 a  input  32  rs operand: multiplicand or dividend.
REQ-007 b  input  32  rt operand: multiplier or divisor.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking the cycle in which a result is committed.
REQ-010 hi  output  32  HI register.
REQ-011 lo  output  32  LO register.
REQ-012 div_by_zero  output  1  one-cycle pulse, coincident with done, when a DIV or DIVU had divisor 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and FIX.
REQ-014 In IDLE, when start=1 and alu_op is one of the four codes in REQ-005, the block SHALL latch a, b and alu_op at that edge (edge k) and enter CALC.
REQ-015 In IDLE, start with any other alu_op SHALL be ignored: no state change, hi/lo unchanged, no pulse.
REQ-016 start while busy=1 SHALL be ignored; a and b changes during busy SHALL NOT affect the result.
REQ-017 CALC SHALL run exactly 32 iterations, one bit per clock, using a 6-bit down-counter; shift-add for multiply, restoring shift-subtract for divide.
REQ-018 Signed ops SHALL operate on operand magnitudes and apply sign correction in FIX.
REQ-019 FIX SHALL last one cycle: hi/lo are written at the edge leaving FIX (edge k+33), done=1 for the following cycle, and the FSM returns to IDLE.
REQ-020 busy SHALL be 1 in the cycles after edges k through k+32 and SHALL be 0 in the done cycle.
REQ-021 A start asserted in the done cycle SHALL be accepted (back-to-back operation).
REQ-022 MULT/MULTU: {hi,lo} SHALL equal the full 64-bit signed or unsigned product.
REQ-023 DIV/DIVU: lo SHALL be the quotient truncated toward zero; hi SHALL be the remainder, with the sign of the dividend for DIV.
REQ-024 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-025 Divide by zero SHALL bypass CALC: IDLE to FIX directly, with done and div_by_zero high after edge k+1, hi=a, lo=32'hFFFFFFFF.
REQ-026 hi and lo SHALL hold their values except at commit.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, counter=0, busy=0, done=0, div_by_zero=0, hi=0 and lo=0.
REQ-028 Reset during CALC or FIX SHALL abort the operation with no commit.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-030 Macro MULDIV_DIV_EN: when defined, DIV and DIVU SHALL behave as specified above.
REQ-031 Without MULDIV_DIV_EN, the divide datapath SHALL be omitted, and DIV/DIVU SHALL be treated as unsupported codes per REQ-015; div_by_zero SHALL be tied to 0.

Verification
REQ-032 MULT a=-3 (32'hFFFFFFFD), b=7 -> done after edge k+33; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high exactly 33 cycles.
REQ-033 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-034 DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=100, b=0 -> done and div_by_zero after edge k+1, hi=100, lo=32'hFFFFFFFF.
REQ-035 Back-to-back: start MULT 5*6 held high, then start again in the done cycle with 2*2 -> first result lo=30, second lo=4, done 34 cycles later; a start with alu_op=6'b100000 is ignored.
REQ-036 Reset asserted at iteration 10 of DIV -> outputs 0 immediately; a new MULT 3*3 after release gives lo=9.
REQ-037 Build without MULDIV_DIV_EN: DIV start -> busy stays 0, no done, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_if.sv
// muldiv_if -- request/result bundle between a control unit and muldiv_unit.
//
// Signals:
//   start        request to begin an operation (sampled on rising clk)
//   alu_op[5:0]  MULT 6'b011000, MULTU 6'b011001, DIV 6'b011010, DIVU 6'b011011
//   a[31:0]      rs operand: multiplicand or dividend
//   b[31:0]      rt operand: multiplier or divisor
//   busy         operation in progress
//   done         one-cycle pulse in the cycle a result is committed
//   hi[31:0]     HI register
//   lo[31:0]     LO register
//   div_by_zero  one-cycle pulse with done when a divide had divisor 0
//
// Modports: master drives the request side, slave is the arithmetic unit.
interface muldiv_if;
   logic        start;
   logic [5:0]  alu_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   modport master (
      output start, alu_op, a, b,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, alu_op, a, b,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32x32 multiply / divide unit with HI/LO registers.
//
// Multiply is a 32-step shift-add on operand magnitudes; divide is a 32-step
// restoring shift-subtract on magnitudes. Signs are applied in a single FIX
// cycle before HI/LO are committed. A divide by zero skips the iteration and
// commits hi=a, lo=32'hFFFFFFFF with a div_by_zero pulse.
//
// Configuration macro: MULDIV_DIV_EN
//   defined   -> DIV/DIVU supported
//   undefined -> divide datapath removed, DIV/DIVU ignored like any other
//                unknown code, div_by_zero held at 0
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  muldiv_if.slave (start, alu_op, a, b in; busy, done, hi, lo,
//        div_by_zero out, all outputs registered)
module muldiv_unit (
   input  logic    clk,
   input  logic    rst,
   muldiv_if.slave bus
);

   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
`ifdef MULDIV_DIV_EN
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Magnitude of a 32-bit operand; 32'h80000000 maps to itself (2^31 unsigned).
   function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
      mag32 = (sgn && x[31]) ? (~x + 32'd1) : x;
   endfunction

   state_t      state_r;
   state_t      state_nxt_s;
   logic [5:0]  cnt_r;
   logic [63:0] work_r;       // multiply: {partial, multiplier}; divide: {remainder, quotient}
   logic [31:0] opnd_r;       // multiplicand magnitude or divisor magnitude
   logic        neg_lo_r;     // product / quotient must be negated
   logic        busy_r;
   logic        done_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;

   logic        op_ok_s;
   logic        op_signed_s;
   logic        zero_div_s;
   logic        load_s;
   logic        commit_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic [63:0] step_s;
   logic [32:0] sum_s;
   logic [63:0] prod_s;
   logic [31:0] res_hi_s;
   logic [31:0] res_lo_s;

`ifdef MULDIV_DIV_EN
   logic        op_div_s;
   logic        is_div_r;
   logic        neg_hi_r;     // remainder takes the dividend sign
   logic        dbz_r;        // current operation is a divide by zero
   logic        dbz_out_r;
   logic [31:0] a_r;          // raw dividend, committed to hi on divide by zero
   logic [32:0] shl_s;
   logic [31:0] diff_s;
   logic        ge_s;
`endif

   // Opcode decode: which codes are accepted and whether they are signed.
   always_comb begin
      op_ok_s     = 1'b0;
      op_signed_s = 1'b0;
`ifdef MULDIV_DIV_EN
      op_div_s    = 1'b0;
`endif
      case (bus.alu_op)
         OP_MULT: begin
            op_ok_s     = 1'b1;
            op_signed_s = 1'b1;
         end
         OP_MULTU: begin
            op_ok_s     = 1'b1;
         end
`ifdef MULDIV_DIV_EN
         OP_DIV: begin
            op_ok_s     = 1'b1;
            op_signed_s = 1'b1;
            op_div_s    = 1'b1;
         end
         OP_DIVU: begin
            op_ok_s     = 1'b1;
            op_div_s    = 1'b1;
         end
`endif
         default: begin
            op_ok_s     = 1'b0;
         end
      endcase
   end

   assign a_mag_s = mag32(bus.a, op_signed_s);
   assign b_mag_s = mag32(bus.b, op_signed_s);

`ifdef MULDIV_DIV_EN
   assign zero_div_s = op_div_s && (bus.b == 32'd0);
`else
   assign zero_div_s = 1'b0;
`endif

   // One iteration of the multiply (and, if built, divide) datapath.
   always_comb begin
      sum_s  = {1'b0, work_r[63:32]} + (work_r[0] ? {1'b0, opnd_r} : 33'd0);
      step_s = {sum_s, work_r[31:1]};
`ifdef MULDIV_DIV_EN
      // Shift the next dividend bit into the partial remainder and try to subtract.
      shl_s  = work_r[63:31];
      ge_s   = (shl_s >= {1'b0, opnd_r});
      diff_s = shl_s[31:0] - opnd_r;
      if (is_div_r) begin
         step_s = {(ge_s ? diff_s : shl_s[31:0]), work_r[30:0], ge_s};
      end else begin
         step_s = {sum_s, work_r[31:1]};
      end
`endif
   end

   // Sign correction of the finished magnitude result.
   always_comb begin
      prod_s   = neg_lo_r ? (~work_r + 64'd1) : work_r;
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
`ifdef MULDIV_DIV_EN
      if (dbz_r) begin
         res_hi_s = a_r;
         res_lo_s = 32'hFFFF_FFFF;
      end else if (is_div_r) begin
         res_hi_s = neg_hi_r ? (~work_r[63:32] + 32'd1) : work_r[63:32];
         res_lo_s = neg_lo_r ? (~work_r[31:0] + 32'd1) : work_r[31:0];
      end else begin
         res_hi_s = prod_s[63:32];
         res_lo_s = prod_s[31:0];
      end
`endif
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state and control strobes.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      commit_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start && op_ok_s) begin
               load_s      = 1'b1;
               state_nxt_s = zero_div_s ? ST_FIX : ST_CALC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            // Counter holds the iterations left, including the current one.
            if (cnt_r == 6'd1) begin
               state_nxt_s = ST_FIX;
            end else begin
               state_nxt_s = ST_CALC;
            end
         end
         ST_FIX: begin
            commit_s    = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Operand capture and iteration datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r    <= 6'd0;
         work_r   <= 64'd0;
         opnd_r   <= 32'd0;
         neg_lo_r <= 1'b0;
`ifdef MULDIV_DIV_EN
         is_div_r <= 1'b0;
         neg_hi_r <= 1'b0;
         dbz_r    <= 1'b0;
         a_r      <= 32'd0;
`endif
      end else if (load_s) begin
         cnt_r    <= zero_div_s ? 6'd0 : 6'd32;
         neg_lo_r <= op_signed_s & (bus.a[31] ^ bus.b[31]);
`ifdef MULDIV_DIV_EN
         is_div_r <= op_div_s;
         neg_hi_r <= op_signed_s & bus.a[31];
         dbz_r    <= zero_div_s;
         a_r      <= bus.a;
         if (op_div_s) begin
            work_r <= {32'd0, a_mag_s};
            opnd_r <= b_mag_s;
         end else begin
            work_r <= {32'd0, b_mag_s};
            opnd_r <= a_mag_s;
         end
`else
         work_r   <= {32'd0, b_mag_s};
         opnd_r   <= a_mag_s;
`endif
      end else if (state_r == ST_CALC) begin
         cnt_r    <= cnt_r - 6'd1;
         work_r   <= step_s;
      end else begin
         cnt_r    <= cnt_r;
         work_r   <= work_r;
      end
   end

   // Registered outputs: busy, done pulse and HI/LO commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         hi_r   <= 32'd0;
         lo_r   <= 32'd0;
      end else begin
         busy_r <= (state_nxt_s != ST_IDLE);
         done_r <= commit_s;
         if (commit_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
         end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
         end
      end
   end

`ifdef MULDIV_DIV_EN
   // Divide-by-zero flag pulses together with done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbz_out_r <= 1'b0;
      end else begin
         dbz_out_r <= commit_s & dbz_r;
      end
   end

   assign bus.div_by_zero = dbz_out_r;
`else
   assign bus.div_by_zero = 1'b0;
`endif

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- self-checking bench for muldiv_unit.
// Reference results come from plain 64-bit arithmetic on the operands; the
// expected HI/LO state is tracked by the bench across operations and resets.
module tb_muldiv_unit;

   localparam logic [5:0] C_MULT  = 6'b011000;
   localparam logic [5:0] C_MULTU = 6'b011001;
   localparam logic [5:0] C_DIV   = 6'b011010;
   localparam logic [5:0] C_DIVU  = 6'b011011;

   logic clk = 1'b0;
   logic rst = 1'b1;

   muldiv_if bus ();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   logic [31:0] mdl_hi = 32'd0;
   logic [31:0] mdl_lo = 32'd0;

   // Reference: is the op accepted, and what HI/LO/div_by_zero result follows.
   function automatic void ref_op(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv,
                                  output bit acc, output logic [31:0] eh, output logic [31:0] el,
                                  output bit edz);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] r;
      sa = $signed(av);
      sb = $signed(bv);
      ua = {32'd0, av};
      ub = {32'd0, bv};
      acc = 1'b0;
      edz = 1'b0;
      eh  = mdl_hi;
      el  = mdl_lo;
      case (op)
         C_MULT:  begin acc = 1'b1; r = sa * sb; eh = r[63:32]; el = r[31:0]; end
         C_MULTU: begin acc = 1'b1; r = ua * ub; eh = r[63:32]; el = r[31:0]; end
`ifdef MULDIV_DIV_EN
         C_DIV: begin
            acc = 1'b1;
            if (bv == 32'd0) begin edz = 1'b1; eh = av; el = 32'hFFFF_FFFF; end
            else begin r = sa / sb; el = r[31:0]; r = sa % sb; eh = r[31:0]; end
         end
         C_DIVU: begin
            acc = 1'b1;
            if (bv == 32'd0) begin edz = 1'b1; eh = av; el = 32'hFFFF_FFFF; end
            else begin r = ua / ub; el = r[31:0]; r = ua % ub; eh = r[31:0]; end
         end
`endif
         default: acc = 1'b0;
      endcase
   endfunction

   // Issue one operation, scramble operands and poke start while busy, then check the result.
   task automatic run_op(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv, input string tag);
      bit acc;
      bit edz;
      logic [31:0] eh;
      logic [31:0] el;
      int e;
      int busy_n;
      int lat;
      ref_op(op, av, bv, acc, eh, el, edz);
      lat = edz ? 1 : 33;
      @(negedge clk);
      bus.start = 1'b1; bus.alu_op = op; bus.a = av; bus.b = bv;
      @(negedge clk);
      bus.start = 1'b0;
      e = 0; busy_n = 0;
      while (bus.done !== 1'b1 && e < 40) begin
         if (bus.busy === 1'b1) busy_n++;
         if (acc && e == 3) begin bus.start = 1'b1; bus.alu_op = C_MULTU; end
         if (e == 4) bus.start = 1'b0;
         if (e == 10) begin
            checks++;
            if (bus.hi !== mdl_hi || bus.lo !== mdl_lo)
               $display("FAIL %s hold: got %h_%h, expected %h_%h", tag, bus.hi, bus.lo, mdl_hi, mdl_lo);
            else passed++;
         end
         bus.a = $urandom; bus.b = $urandom;
         @(negedge clk);
         e++;
      end
      if (acc) begin
         checks++;
         if (e !== lat) $display("FAIL %s latency: got %0d, expected %0d", tag, e, lat); else passed++;
         checks++;
         if (busy_n !== lat) $display("FAIL %s busy_cycles: got %0d, expected %0d", tag, busy_n, lat); else passed++;
         checks++;
         if (bus.busy !== 1'b0) $display("FAIL %s busy_in_done: got %b, expected 0", tag, bus.busy); else passed++;
         checks++;
         if (bus.hi !== eh) $display("FAIL %s hi: got %h, expected %h", tag, bus.hi, eh); else passed++;
         checks++;
         if (bus.lo !== el) $display("FAIL %s lo: got %h, expected %h", tag, bus.lo, el); else passed++;
         checks++;
         if (bus.div_by_zero !== edz) $display("FAIL %s dbz: got %b, expected %b", tag, bus.div_by_zero, edz); else passed++;
         mdl_hi = eh; mdl_lo = el;
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0)
            $display("FAIL %s pulse_width: got done=%b dbz=%b, expected 0 0", tag, bus.done, bus.div_by_zero);
         else passed++;
      end else begin
         checks++;
         if (e !== 40) $display("FAIL %s ignored_done: got done after %0d cycles, expected none", tag, e); else passed++;
         checks++;
         if (busy_n !== 0) $display("FAIL %s ignored_busy: got %0d busy cycles, expected 0", tag, busy_n); else passed++;
         checks++;
         if (bus.hi !== mdl_hi || bus.lo !== mdl_lo)
            $display("FAIL %s ignored_hilo: got %h_%h, expected %h_%h", tag, bus.hi, bus.lo, mdl_hi, mdl_lo);
         else passed++;
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.alu_op = 6'd0; bus.a = 32'd0; bus.b = 32'd0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
         $display("FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all 0",
                  bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
      else passed++;
      rst = 1'b0;
      mdl_hi = 32'd0; mdl_lo = 32'd0;
   endtask

   task automatic test_mult();
      run_op(C_MULT,  32'hFFFF_FFFD, 32'd7,         "mult_neg3x7");
      run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      run_op(C_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minxmin");
      run_op(C_MULT,  32'h1234_5678, 32'd0,         "mult_zero");
      run_op(C_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, "mult_maxxneg1");
   endtask

   task automatic test_div();
      run_op(C_DIV,  32'hFFFF_FFF9, 32'd2,         "div_neg7by2");
      run_op(C_DIVU, 32'd100,       32'd0,         "divu_by0");
      run_op(C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_min_neg1");
      run_op(C_DIV,  32'hFFFF_FF00, 32'd0,         "div_by0");
      run_op(C_DIVU, 32'hFFFF_FFFF, 32'd1,         "divu_by1");
      run_op(C_DIV,  32'd7,         32'hFFFF_FFFE, "div_7byneg2");
   endtask

   task automatic test_random();
      logic [5:0] ops [4];
      logic [31:0] av;
      logic [31:0] bv;
      ops[0] = C_MULT; ops[1] = C_MULTU; ops[2] = C_DIV; ops[3] = C_DIVU;
      for (int i = 0; i < 24; i++) begin
         av = $urandom;
         bv = $urandom;
         if ($urandom_range(0, 3) == 0) bv = bv >> $urandom_range(16, 31);
         run_op(ops[$urandom_range(0, 3)], av, bv, "random");
      end
   endtask

   task automatic test_back_to_back();
      int e;
      bit acc;
      bit edz;
      logic [31:0] eh;
      logic [31:0] el;
      @(negedge clk);
      bus.start = 1'b1; bus.alu_op = C_MULT; bus.a = 32'd5; bus.b = 32'd6;
      @(negedge clk);
      e = 0;
      while (bus.done !== 1'b1 && e < 40) begin @(negedge clk); e++; end
      ref_op(C_MULT, 32'd5, 32'd6, acc, eh, el, edz);
      checks++;
      if (bus.done !== 1'b1 || bus.lo !== el)
         $display("FAIL b2b_first: got done=%b lo=%h, expected 1 %h", bus.done, bus.lo, el);
      else passed++;
      mdl_hi = eh; mdl_lo = el;
      bus.a = 32'd2; bus.b = 32'd2;
      @(negedge clk);
      bus.start = 1'b0;
      e = 1;
      checks++;
      if (bus.busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b, expected 1", bus.busy); else passed++;
      while (bus.done !== 1'b1 && e < 45) begin @(negedge clk); e++; end
      ref_op(C_MULT, 32'd2, 32'd2, acc, eh, el, edz);
      checks++;
      if (e !== 34) $display("FAIL b2b_spacing: got %0d, expected 34", e); else passed++;
      checks++;
      if (bus.lo !== el || bus.hi !== eh) $display("FAIL b2b_second: got %h_%h, expected %h_%h", bus.hi, bus.lo, eh, el);
      else passed++;
      mdl_hi = eh; mdl_lo = el;
      run_op(6'b100000, 32'd9, 32'd9, "ignored_op");
   endtask

   task automatic test_reset_mid();
`ifdef MULDIV_DIV_EN
      logic [5:0] op = C_DIV;
`else
      logic [5:0] op = C_MULT;
`endif
      @(negedge clk);
      bus.start = 1'b1; bus.alu_op = op; bus.a = $urandom; bus.b = $urandom | 32'd1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b, expected 1", bus.busy); else passed++;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
         $display("FAIL rstmid_clear: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all 0",
                  bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
      else passed++;
      mdl_hi = 32'd0; mdl_lo = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      run_op(C_MULT, 32'd3, 32'd3, "after_reset_3x3");
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
